// File: rtl/neat_gene_pkg.sv
// Shared gene layout for the NEAT mutation datapath: field indices, type-bit position, gene type.
package neat_gene_pkg;
  localparam int GENE_SZ_D = 64;
  localparam int ATTR_SZ_D = 8;

  localparam int F_GENOME = 7;
  localparam int F_TYPE   = 6;
  localparam int F_SRC    = 5;
  localparam int F_DEST   = 4;

  // Top bit of the type field: 1 = connection gene, 0 = node gene.
  localparam int CONN_TYPE_BIT = (F_TYPE + 1) * ATTR_SZ_D - 1;

  typedef logic [GENE_SZ_D-1:0] gene_t;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/gene_fifo_mem.sv
// DEPTH x GENE_SZ gene storage: three write ports (distinct addresses), one async read port.
module gene_fifo_mem #(
  parameter int GENE_SZ = 64,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic [2:0]             we,
  input  logic [2:0][AW-1:0]     waddr,
  input  logic [2:0][GENE_SZ-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [GENE_SZ-1:0]     rdata
);
  logic [GENE_SZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int j = 0; j < 3; j++)
      if (we[j]) mem[waddr[j]] <= wdata[j];
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/gene_stream_compactor.sv
// Compacts up to three valid genes per cycle into an in-order single-gene valid/ready stream.
// Optional GENE_STREAM_STATS_EN adds saturating accepted_genes / dropped_groups counters.
module gene_stream_compactor
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int DEPTH   = 16,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [GENE_SZ-1:0] gene_in1,
  input  logic [GENE_SZ-1:0] gene_in2,
  input  logic [GENE_SZ-1:0] gene_in3,
  input  logic [2:0]         in_valid,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               almost_full,
  output logic               overflow,
  output logic [CW-1:0]      count,
  output logic [ATTR_SZ-1:0] hidden_node_max
`ifdef GENE_STREAM_STATS_EN
  ,
  output logic [15:0]        accepted_genes,
  output logic [15:0]        dropped_groups
`endif
);
  localparam int TYPE_BIT = (F_TYPE + 1) * ATTR_SZ - 1;

  logic [2:0][GENE_SZ-1:0] slot;
  logic [2:0][GENE_SZ-1:0] wdata;
  logic [2:0][PW-1:0]      waddr;
  logic [2:0]              we;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [1:0]              n;
  logic [CW-1:0]           free;
  logic                    fits, push, drop, pop;
  logic [ATTR_SZ-1:0]      grp_max;
  logic [GENE_SZ-1:0]      rd_data;

  assign slot = {gene_in3, gene_in2, gene_in1};
  assign n    = popcnt3(in_valid);
  assign free = CW'(DEPTH) - count;
  assign fits = CW'(n) <= free;
  assign push = fits && (n != 2'd0) && !flush;
  assign drop = !fits && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Port j carries the (j+1)-th valid slot in slot order.
  always_comb begin
    wdata[0] = in_valid[0] ? gene_in1 : (in_valid[1] ? gene_in2 : gene_in3);
    wdata[1] = (in_valid[0] && in_valid[1]) ? gene_in2 : gene_in3;
    wdata[2] = gene_in3;
    for (int j = 0; j < 3; j++) begin
      waddr[j] = wr_ptr + PW'(j);
      we[j]    = rst && push && (n > 2'(j));
    end
  end

  always_comb begin
    grp_max = hidden_node_max;
    for (int k = 0; k < 3; k++)
      if (in_valid[k] && !slot[k][TYPE_BIT] &&
          slot[k][F_SRC*ATTR_SZ +: ATTR_SZ] > grp_max)
        grp_max = slot[k][F_SRC*ATTR_SZ +: ATTR_SZ];
  end

  gene_fifo_mem #(.GENE_SZ(GENE_SZ), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      overflow        <= 1'b0;
      hidden_node_max <= '0;
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(n);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (push ? CW'(n) : CW'(0)) - CW'(pop);
      if (drop) overflow <= 1'b1;
      if (push) hidden_node_max <= grp_max;
    end
  end

  // Memory is unreset, so mask the head while empty.
  assign out_valid   = count != '0;
  assign gene_out    = out_valid ? rd_data : '0;
  assign almost_full = free < CW'(3);

`ifdef GENE_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      accepted_genes <= '0;
      dropped_groups <= '0;
    end else begin
      if (push)
        accepted_genes <= (17'(accepted_genes) + 17'(n) > 17'h0FFFF) ? 16'hFFFF
                          : accepted_genes + 16'(n);
      if (drop && dropped_groups != 16'hFFFF)
        dropped_groups <= dropped_groups + 16'd1;
    end
  end
`endif
endmodule
